fcpu_rob: RTL and testbench
===========================

Name: fcpu_rob

Overview:
In-order retirement side of the out-of-order core. The block allocates reorder-buffer entries at dispatch and captures results broadcast on the common data bus (tag plus data, CDB_W bits wide). It commits entries strictly in program order to the register file, FPU register file, memory and branch units. A committed branch marked invalidate squashes all younger entries via a one-cycle flush.

Parameters:
N_ROB_W, 4, log2 of entry count (16 entries)
DATA_W, 32, result width
REG_ADDR_W, 5, destination register address width
RSV_ID_W, 5, CDB tag width; the low N_ROB_W bits index the entry, upper bits are ignored

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alloc_valid  in  1  dispatch requests an entry
alloc_ready  out  1  entry available
alloc_dst_reg  in  REG_ADDR_W  destination register
alloc_type  in  3  commit_type_t of the instruction
alloc_tag  out  N_ROB_W  index handed out (current tail); valid whenever alloc_ready=1
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  RSV_ID_W  producing entry tag
cdb_data  in  DATA_W  result
cdb_invalidate  in  1  branch mispredicted (meaningful for branch entries only)
lookup_tag  in  N_ROB_W  operand forwarding query
lookup_ready  out  1  queried entry allocated and complete (combinational)
lookup_data  out  DATA_W  queried entry data (combinational)
commit_valid  out  1  head entry complete
commit_ready  in  1  consumer accepts the head entry
commit_tag  out  N_ROB_W  head index
commit_dst_reg  out  REG_ADDR_W  head destination
commit_type  out  3  head commit_type_t
commit_data  out  DATA_W  head result
flush  out  1  squash pulse
count  out  N_ROB_W+1  occupied entries

Behaviour:
- Storage per entry: busy, done, invalidate, dst_reg, type, data. Pointers head and tail are N_ROB_W+1 bits wide; the index is the low N_ROB_W bits, and the MSB disambiguates full from empty.
- Reset: all busy/done cleared, head=tail=0, count=0, flush=0, commit_valid=0, alloc_ready=1.
- alloc_ready = (count != 2**N_ROB_W) && !flush. It does not depend on a same-cycle commit, so no full-bypass.
- Allocation fires when alloc_valid && alloc_ready. Tail entry gets busy=1, done=0, invalidate=0, dst and type stored; tail increments and wraps naturally.
- CDB write: if cdb_valid and entry[cdb_tag[N_ROB_W-1:0]].busy, set done=1, capture data and invalidate. A write to a non-busy entry is ignored. A write to an already-done entry overwrites the stored data.
- commit_valid = entry[head].busy && entry[head].done. The commit_* outputs come straight from the head entry's registers.
- Latency: a CDB write becomes visible on commit_valid and lookup_* in the following cycle.
- Commit fires when commit_valid && commit_ready. Head entry busy and done are cleared, and head increments.
- Simultaneous events:
  - Allocation plus commit in the same cycle: count unchanged.
  - Allocation plus CDB write to the same index: cannot occur; that index is not busy.
  - CDB write plus commit on the head entry: the commit uses the old (already done) data.
- Mispredict: a commit firing on a type=commit_branch entry with invalidate=1 registers flush=1 for the next cycle only.
  - At that same edge all busy/done bits are cleared, head=tail=0, count=0.
  - An allocation offered in that cycle is dropped.
  - While flush=1, alloc_ready=0 and CDB writes are ignored.
- rst mid-operation discards all entries with no commit and no flush pulse.
- count = tail - head, in N_ROB_W+1-bit modular arithmetic.

Optional Feature:
FCPU_ROB_BYPASS_EN:
- Defined: CDB-to-commit bypass. If cdb_valid targets the busy, not-done head entry, commit_valid asserts in that same cycle, with commit_data=cdb_data and the invalidate decision taken from cdb_invalidate. A commit firing that cycle still retires the entry.
- Undefined: no bypass; the baseline one-cycle latency applies.

Test Plan:
- After reset, allocate 16 entries back-to-back -> alloc_tag 0..15, count=16, alloc_ready=0 in the cycle after the 16th allocation. A 17th alloc_valid is not accepted.
- Allocate 3 entries; CDB completes tags 2, 0, 1 with data 0x22, 0x00, 0x11 -> commits in order 0, 1, 2 with matching data. Nothing commits before tag 0 is done.
- Fill to 16, commit 4, allocate 4 -> new tags 0..3 (wrap), count=16, and commit order continues 4, 5, ... 15, 0.
- Branch at tag 1 completes with cdb_invalidate=1, younger tags 2..5 done -> after tag 1 commits, flush=1 for exactly one cycle, count=0, next alloc_tag=0, tags 2..5 never commit.
- cdb_valid with tag 9 while only 0..3 are busy -> no state change, lookup_ready for tag 9 stays 0.
- With FCPU_ROB_BYPASS_EN defined, CDB completes the head with 0xDEADBEEF and commit_ready=1 -> commit fires the same cycle with commit_data=0xDEADBEEF. With it undefined, the commit fires one cycle later.

Source files
------------

// File: rtl/fcpu_rob_if.sv
// fcpu_rob_if: dispatch, CDB, lookup and commit signals of the reorder buffer.
// The master side is the core (dispatch, execution units and commit consumers).
// The slave side is the ROB.
interface fcpu_rob_if #(
    parameter int N_ROB_W    = 4,
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int RSV_ID_W   = 5
);
    logic                  alloc_valid;
    logic                  alloc_ready;
    logic [REG_ADDR_W-1:0] alloc_dst_reg;
    logic [2:0]            alloc_type;
    logic [N_ROB_W-1:0]    alloc_tag;

    logic                  cdb_valid;
    logic [RSV_ID_W-1:0]   cdb_tag;
    logic [DATA_W-1:0]     cdb_data;
    logic                  cdb_invalidate;

    logic [N_ROB_W-1:0]    lookup_tag;
    logic                  lookup_ready;
    logic [DATA_W-1:0]     lookup_data;

    logic                  commit_valid;
    logic                  commit_ready;
    logic [N_ROB_W-1:0]    commit_tag;
    logic [REG_ADDR_W-1:0] commit_dst_reg;
    logic [2:0]            commit_type;
    logic [DATA_W-1:0]     commit_data;

    logic                  flush;
    logic [N_ROB_W:0]      count;

    modport master (
        output alloc_valid, alloc_dst_reg, alloc_type,
        output cdb_valid, cdb_tag, cdb_data, cdb_invalidate,
        output lookup_tag, commit_ready,
        input  alloc_ready, alloc_tag, lookup_ready, lookup_data,
        input  commit_valid, commit_tag, commit_dst_reg, commit_type, commit_data,
        input  flush, count
    );

    modport slave (
        input  alloc_valid, alloc_dst_reg, alloc_type,
        input  cdb_valid, cdb_tag, cdb_data, cdb_invalidate,
        input  lookup_tag, commit_ready,
        output alloc_ready, alloc_tag, lookup_ready, lookup_data,
        output commit_valid, commit_tag, commit_dst_reg, commit_type, commit_data,
        output flush, count
    );
endinterface

// File: rtl/fcpu_rob.sv
// fcpu_rob: reorder buffer with in-order commit and branch-mispredict flush.
// commit_type encoding: 0 int reg, 1 fpu reg, 2 memory, 3 branch, others reserved.
// Optional macro FCPU_ROB_BYPASS_EN: a CDB write to the busy, not-done head
// entry is presented on the commit outputs in the same cycle.
module fcpu_rob #(
    parameter int N_ROB_W    = 4,
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int RSV_ID_W   = 5
) (
    input logic       clk,
    input logic       rst,
    fcpu_rob_if.slave rob
);
    localparam int               ENTRIES       = 1 << N_ROB_W;
    localparam logic [2:0]       COMMIT_BRANCH = 3'd3;
    localparam logic [N_ROB_W:0] FULL          = {1'b1, {N_ROB_W{1'b0}}};
    localparam logic [N_ROB_W:0] PTR_ONE       = {{N_ROB_W{1'b0}}, 1'b1};

    logic [ENTRIES-1:0]    busy_q, done_q, inv_q;
    logic [REG_ADDR_W-1:0] dst_q  [ENTRIES];
    logic [2:0]            type_q [ENTRIES];
    logic [DATA_W-1:0]     data_q [ENTRIES];
    logic [N_ROB_W:0]      head_q, tail_q, count;
    logic                  flush_q;

    logic [N_ROB_W-1:0]    head_idx, tail_idx, cdb_idx;
    logic                  alloc_ready, alloc_fire, cdb_hit;
    logic                  commit_valid, commit_fire, commit_inv, mispredict;
    logic [DATA_W-1:0]     commit_data;
    logic                  unused_cdb_tag_hi;

    assign head_idx          = head_q[N_ROB_W-1:0];
    assign tail_idx          = tail_q[N_ROB_W-1:0];
    assign cdb_idx           = rob.cdb_tag[N_ROB_W-1:0];
    assign unused_cdb_tag_hi = ^rob.cdb_tag[RSV_ID_W-1:N_ROB_W];

    assign count       = tail_q - head_q;
    assign alloc_ready = (count != FULL) && !flush_q;
    assign alloc_fire  = rob.alloc_valid && alloc_ready;
    assign cdb_hit     = rob.cdb_valid && busy_q[cdb_idx] && !flush_q;

    // Head entry commit decision, optionally bypassing a same-cycle CDB result
    always_comb begin
        commit_valid = busy_q[head_idx] && done_q[head_idx];
        commit_data  = data_q[head_idx];
        commit_inv   = inv_q[head_idx];
`ifdef FCPU_ROB_BYPASS_EN
        if (cdb_hit && (cdb_idx == head_idx) && !done_q[head_idx]) begin
            commit_valid = 1'b1;
            commit_data  = rob.cdb_data;
            commit_inv   = rob.cdb_invalidate;
        end
`else
`endif
    end

    assign commit_fire = commit_valid && rob.commit_ready;
    assign mispredict  = commit_fire && (type_q[head_idx] == COMMIT_BRANCH) && commit_inv;

    assign rob.alloc_ready    = alloc_ready;
    assign rob.alloc_tag      = tail_idx;
    assign rob.commit_valid   = commit_valid;
    assign rob.commit_tag     = head_idx;
    assign rob.commit_dst_reg = dst_q[head_idx];
    assign rob.commit_type    = type_q[head_idx];
    assign rob.commit_data    = commit_data;
    assign rob.lookup_ready   = busy_q[rob.lookup_tag] && done_q[rob.lookup_tag];
    assign rob.lookup_data    = data_q[rob.lookup_tag];
    assign rob.flush          = flush_q;
    assign rob.count          = count;

    // Entry state and pointers: allocate at tail, complete from CDB, retire at head
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            done_q  <= '0;
            inv_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            flush_q <= 1'b0;
        end else begin
            flush_q <= mispredict;
            if (mispredict) begin
                busy_q <= '0;
                done_q <= '0;
                head_q <= '0;
                tail_q <= '0;
            end else begin
                if (alloc_fire) begin
                    busy_q[tail_idx] <= 1'b1;
                    done_q[tail_idx] <= 1'b0;
                    inv_q[tail_idx]  <= 1'b0;
                    dst_q[tail_idx]  <= rob.alloc_dst_reg;
                    type_q[tail_idx] <= rob.alloc_type;
                    tail_q           <= tail_q + PTR_ONE;
                end
                if (cdb_hit) begin
                    done_q[cdb_idx] <= 1'b1;
                    inv_q[cdb_idx]  <= rob.cdb_invalidate;
                    data_q[cdb_idx] <= rob.cdb_data;
                end
                // Retirement comes last so it wins over a CDB write to the head
                if (commit_fire) begin
                    busy_q[head_idx] <= 1'b0;
                    done_q[head_idx] <= 1'b0;
                    head_q           <= head_q + PTR_ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_fcpu_rob.sv
// tb_fcpu_rob: directed and random stimulus for fcpu_rob against a queue-based
// reference model; expected commits go through a scoreboard queue.
module tb_fcpu_rob;
    localparam int BR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    fcpu_rob_if bus ();
    fcpu_rob dut (.clk(clk), .rst(rst), .rob(bus));

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        int          dst;
        int          typ;
        logic [31:0] data;
        bit          done;
        bit          inv;
    } ent_t;

    typedef struct {
        int          tag;
        int          dst;
        int          typ;
        logic [31:0] data;
    } cmt_t;

    ent_t rob_m[$];
    cmt_t exp_q[$];
    int   next_tag = 0;
    bit   flush_m = 0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_commit_cyc = -1;
    bit chk_en = 0;

    int          exp_count;
    bit          exp_ar, exp_flush, exp_cv, exp_lr;
    int          exp_atag;
    logic [31:0] exp_ld;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare visible outputs with the model, pop the scoreboard on each commit
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", 64'(bus.count), 64'(exp_count));
            chk("alloc_ready", 64'(bus.alloc_ready), 64'(exp_ar));
            if (exp_ar) chk("alloc_tag", 64'(bus.alloc_tag), 64'(exp_atag));
            chk("flush", 64'(bus.flush), 64'(exp_flush));
            chk("commit_valid", 64'(bus.commit_valid), 64'(exp_cv));
            chk("lookup_ready", 64'(bus.lookup_ready), 64'(exp_lr));
            if (exp_lr) chk("lookup_data", 64'(bus.lookup_data), 64'(exp_ld));
            if (bus.commit_valid && bus.commit_ready) begin
                last_commit_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_commit", 64'(bus.commit_tag), 64'hFFFF);
                end else begin
                    cmt_t e;
                    e = exp_q.pop_front();
                    chk("commit_tag", 64'(bus.commit_tag), 64'(e.tag));
                    chk("commit_dst", 64'(bus.commit_dst_reg), 64'(e.dst));
                    chk("commit_type", 64'(bus.commit_type), 64'(e.typ));
                    chk("commit_data", 64'(bus.commit_data), 64'(e.data));
                end
            end
        end
    end

    // One clock cycle: drive inputs, predict outputs from the model, advance the model
    task automatic step(input bit av, input int dst, input int typ, input bit cv,
                        input int ctag, input logic [31:0] cd, input bit ci,
                        input bit cr, input int lt);
        int          cpos;
        bit          cval, fire, misp, afire;
        logic [31:0] cdat;
        bit          cinv;
        bus.alloc_valid    = av;
        bus.alloc_dst_reg  = 5'(dst);
        bus.alloc_type     = 3'(typ);
        bus.cdb_valid      = cv;
        bus.cdb_tag        = 5'(ctag);
        bus.cdb_data       = cd;
        bus.cdb_invalidate = ci;
        bus.commit_ready   = cr;
        bus.lookup_tag     = 4'(lt);

        exp_count = rob_m.size();
        exp_ar    = (rob_m.size() < 16) && !flush_m;
        exp_atag  = next_tag;
        exp_flush = flush_m;
        cpos = -1;
        if (cv && !flush_m)
            for (int i = 0; i < rob_m.size(); i++)
                if (rob_m[i].tag == ctag % 16) cpos = i;
        cval = 0; cdat = '0; cinv = 0;
        if (rob_m.size() > 0) begin
            cval = rob_m[0].done;
            cdat = rob_m[0].data;
            cinv = rob_m[0].inv;
`ifdef FCPU_ROB_BYPASS_EN
            if (!cval && cpos == 0) begin
                cval = 1;
                cdat = cd;
                cinv = ci;
            end
`endif
        end
        exp_cv = cval;
        exp_lr = 0; exp_ld = '0;
        for (int i = 0; i < rob_m.size(); i++)
            if (rob_m[i].tag == lt && rob_m[i].done) begin
                exp_lr = 1;
                exp_ld = rob_m[i].data;
            end
        fire  = cval && cr;
        misp  = fire && (rob_m[0].typ == BR) && cinv;
        afire = av && exp_ar;
        if (fire) exp_q.push_back('{rob_m[0].tag, rob_m[0].dst, rob_m[0].typ, cdat});

        @(posedge clk); #1;

        if (misp) begin
            rob_m.delete();
            next_tag = 0;
            flush_m  = 1;
        end else begin
            flush_m = 0;
            if (cpos >= 0) begin
                ent_t e;
                e = rob_m[cpos];
                e.done = 1; e.data = cd; e.inv = ci;
                rob_m[cpos] = e;
            end
            if (fire) void'(rob_m.pop_front());
            if (afire) begin
                rob_m.push_back('{next_tag, dst, typ, 32'h0, 1'b0, 1'b0});
                next_tag = (next_tag + 1) % 16;
            end
        end
    endtask

    task automatic alloc(input int typ, input bit cr);
        step(1, int'($urandom_range(0, 31)), typ, 0, 0, 32'h0, 0, cr, 0);
    endtask

    task automatic cdb(input int tag, input logic [31:0] d, input bit inv, input bit cr);
        step(0, 0, 0, 1, tag, d, inv, cr, tag % 16);
    endtask

    task automatic idle(input int n, input bit cr);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h0, 0, cr, i % 16);
    endtask

    task automatic do_reset();
        chk_en = 0;
        rst = 1;
        bus.alloc_valid = 0; bus.cdb_valid = 0; bus.commit_ready = 0;
        bus.alloc_dst_reg = '0; bus.alloc_type = '0; bus.cdb_tag = '0;
        bus.cdb_data = '0; bus.cdb_invalidate = 0; bus.lookup_tag = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pending_commits", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        rob_m.delete();
        next_tag = 0;
        flush_m  = 0;
        rst = 0;
        chk_en = 1;
    endtask

    initial begin
        int c0, ctag;
        do_reset();
        chk("reset_count", 64'(bus.count), 64'd0);
        chk("reset_alloc_ready", 64'(bus.alloc_ready), 64'd1);
        chk("reset_commit_valid", 64'(bus.commit_valid), 64'd0);
        chk("reset_flush", 64'(bus.flush), 64'd0);

        // Fill all 16 entries plus one refused request
        for (int i = 0; i < 17; i++) alloc(0, 1);
        idle(1, 1);

        // Out-of-order completion, in-order commit
        do_reset();
        for (int i = 0; i < 3; i++) alloc(1, 1);
        cdb(2, 32'h22, 0, 1);
        cdb(0, 32'h00, 0, 1);
        cdb(1, 32'h11, 0, 1);
        idle(3, 1);

        // Wrap-around of the tail and head
        do_reset();
        for (int i = 0; i < 16; i++) alloc(2, 0);
        for (int i = 0; i < 16; i++) cdb(i, 32'(i * 32'h101), 0, 0);
        idle(4, 1);
        for (int i = 0; i < 4; i++) alloc(0, 0);
        for (int i = 0; i < 4; i++) cdb(i + 16, 32'hA000 + 32'(i), 0, 0);
        idle(18, 1);

        // Mispredicted branch at tag 1 squashes tags 2..5
        do_reset();
        alloc(0, 1); alloc(BR, 1);
        for (int i = 0; i < 4; i++) alloc(0, 1);
        for (int i = 2; i < 6; i++) cdb(i, 32'h500 + 32'(i), 0, 1);
        cdb(0, 32'h50, 0, 1);
        cdb(1, 32'h51, 1, 1);
        alloc(0, 1);
        idle(4, 1);
        alloc(0, 1);
        idle(2, 1);

        // CDB write to a non-busy entry is ignored
        do_reset();
        for (int i = 0; i < 4; i++) alloc(0, 0);
        step(0, 0, 0, 1, 9, 32'h99, 0, 0, 9);
        step(0, 0, 0, 0, 0, 32'h0, 0, 0, 9);
        step(0, 0, 0, 1, 25, 32'h98, 0, 0, 9);
        step(0, 0, 0, 0, 0, 32'h0, 0, 1, 9);

        // Head completion latency (same cycle with bypass, next cycle without)
        do_reset();
        alloc(0, 0);
        c0 = cyc;
        cdb(0, 32'hDEADBEEF, 0, 1);
        idle(2, 1);
`ifdef FCPU_ROB_BYPASS_EN
        chk("head_commit_latency", 64'(last_commit_cyc - c0), 64'd0);
`else
        chk("head_commit_latency", 64'(last_commit_cyc - c0), 64'd1);
`endif

        // Random traffic with occasional mid-run resets
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if (n % 500 == 499) do_reset();
            if (rob_m.size() > 0 && $urandom_range(0, 4) != 0)
                ctag = rob_m[$urandom_range(0, rob_m.size() - 1)].tag + 16 * int'($urandom_range(0, 1));
            else
                ctag = int'($urandom_range(0, 31));
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 4)), $urandom_range(0, 9) < 7, ctag,
                 $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 15)));
        end
        idle(2, 0);
        chk("final_pending_commits", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1);
    end
endmodule
